// File: rtl/vote_pkg.sv
// vote_pkg -- shared definitions for the ballot-collection stage.
//   NUM_VOTERS   : number of voters feeding the majority decoder (4)
//   vote_state_t : session state (IDLE, OPEN, DONE)
//   ballot_t     : one bit per voter, 1 = yes
package vote_pkg;

  localparam int NUM_VOTERS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    DONE = 2'd2
  } vote_state_t;

  typedef logic [NUM_VOTERS-1:0] ballot_t;

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect -- rising-edge detector for a bank of pre-synchronised
// button levels. The history register samples every cycle regardless of
// what the consumer is doing, so a button held across a session boundary
// produces no edge until it is released and pressed again.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears history)
//   btn  : [WIDTH] button levels
//   rise : [WIDTH] one-cycle pulse where btn is 1 and was 0 last cycle
module btn_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) hist <= '0;
    else     hist <= btn;
  end

  assign rise = btn & ~hist;

endmodule

// File: rtl/vote_collector.sv
// vote_collector -- opens a voting session on start, records one yes/no vote
// per voter from button edges, closes on close / all votes cast / timeout,
// then holds the ballot with a valid/ack handshake for the majority decoder.
// Unvoted voters read as "no" (ballot bit 0).
//
// Optional feature: define VOTE_TIMEOUT_EN to build the session timer, the
// timeout close condition and the timed_out flag. Without it the session
// closes only on close or four votes, and timed_out is constant 0.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   start        : pulse, opens a session (IDLE only)
//   close        : pulse, ends the session early (OPEN only)
//   yes_btn[4]   : per-voter yes button level
//   no_btn[4]    : per-voter no button level
//   ack          : consumer has sampled the ballot (DONE only)
//   ballot[4]    : bit i = voter i voted yes
//   ballot_valid : high throughout DONE
//   voting_open  : high throughout OPEN
//   voted[4]     : bit i = voter i has voted this session
//   timed_out    : session closed by timeout; cleared on start
module vote_collector
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  close,
  input  logic [NUM_VOTERS-1:0] yes_btn,
  input  logic [NUM_VOTERS-1:0] no_btn,
  input  logic                  ack,
  output ballot_t               ballot,
  output logic                  ballot_valid,
  output logic                  voting_open,
  output logic [NUM_VOTERS-1:0] voted,
  output logic                  timed_out
);

  vote_state_t           state;
  logic [NUM_VOTERS-1:0] yes_rise;
  logic [NUM_VOTERS-1:0] no_rise;
  logic [NUM_VOTERS-1:0] accept;
  logic [NUM_VOTERS-1:0] voted_next;
  ballot_t               ballot_next;
  logic                  all_voted;
  logic                  tmr_expired;

  btn_edge_detect #(.WIDTH(NUM_VOTERS)) u_yes_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (yes_btn),
    .rise (yes_rise)
  );

  btn_edge_detect #(.WIDTH(NUM_VOTERS)) u_no_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (no_btn),
    .rise (no_rise)
  );

`ifdef VOTE_TIMEOUT_EN
  logic [TMR_W-1:0] timer;
  assign tmr_expired = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmr_expired = 1'b0;
  assign timed_out   = 1'b0;
  // Timer configuration has no effect without the timeout feature.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == TMR_W);
`endif

  // A vote needs exactly one edge (yes XOR no) from a voter that has not yet
  // voted; a simultaneous yes+no press is dropped and the voter may retry.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    accept      = '0;
    voted_next  = voted;
    ballot_next = ballot;
    accept      = ~voted & (yes_rise ^ no_rise);
    voted_next  = voted | accept;
    ballot_next = (ballot & ~accept) | (yes_rise & accept);
  end

  assign all_voted = &voted_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ballot       <= '0;
      voted        <= '0;
      ballot_valid <= 1'b0;
      voting_open  <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      timer        <= '0;
      timed_out    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= OPEN;
            voting_open <= 1'b1;
            ballot      <= '0;
            voted       <= '0;
`ifdef VOTE_TIMEOUT_EN
            timer       <= '0;
            timed_out   <= 1'b0;
`endif
          end
        end

        OPEN: begin
          // Votes arriving on the closing cycle still count.
          ballot <= ballot_next;
          voted  <= voted_next;
          if (close || all_voted || tmr_expired) begin
            state        <= DONE;
            voting_open  <= 1'b0;
            ballot_valid <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
            // Only attribute the close to the timer when nothing else fired.
            timed_out    <= !close && !all_voted;
`endif
          end else begin
`ifdef VOTE_TIMEOUT_EN
            timer <= timer + TMR_W'(1);
`endif
          end
        end

        DONE: begin
          if (ack) begin
            state        <= IDLE;
            ballot_valid <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          voting_open  <= 1'b0;
          ballot_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vote_collector.md
# vote_collector

Ballot-collection stage that sits directly upstream of the four-voter majority decoder. It opens a voting session on command, accepts exactly one yes/no vote per voter from button inputs, and closes the session on command, on all four votes cast, or on timeout. It then holds the 4-bit ballot stable with a valid/ack handshake so the decoder's pass/tie/fail result can be sampled. Unvoted voters are recorded as "no" (bit 0), matching the decoder's encoding.

## Interface
- `TIMEOUT_CYCLES`, default 1000: voting-window length in clock cycles; legal range 1..65535.
- `TMR_W`, default 16: timer width; TIMEOUT_CYCLES-1 must fit.

- `clk`: in, 1. Single clock; all logic is rising-edge.
- `rst`: in, 1. Synchronous, active-high reset.
- `start`: in, 1. Single-cycle pulse that opens a session; honoured only in IDLE.
- `close`: in, 1. Single-cycle pulse that ends the session early; honoured only in OPEN.
- `yes_btn`: in, 4. Per-voter "yes" button; level, pre-synchronised.
- `no_btn`: in, 4. Per-voter "no" button; level, pre-synchronised.
- `ack`: in, 1. Consumer has sampled the ballot; honoured only in DONE.
- `ballot`: out, 4. Bit i is 1 if voter i voted yes; drives the majority decoder input.
- `ballot_valid`: out, 1. High throughout DONE.
- `voting_open`: out, 1. High throughout OPEN.
- `voted`: out, 4. Bit i is 1 once voter i's vote is recorded in the current session.
- `timed_out`: out, 1. Set when the session closes by timeout; cleared on `start`.

## Operation
- Reset: state is IDLE. `ballot`, `voted`, `ballot_valid`, `voting_open`, `timed_out`, the timer, and the button history registers are all 0.
- Edge detection: the history registers sample `yes_btn` and `no_btn` every cycle in all states. A vote is a 0→1 edge only, so a button held across `start` does not count until it is released and pressed again.
- States: IDLE, OPEN, DONE.
- **IDLE**
  - `start`: go to OPEN. Clear `ballot`, `voted`, `timed_out` and the timer.
  - All other inputs are ignored. `ballot` keeps the last session's value.
- **OPEN** — per voter i, evaluated independently each cycle:
  - If `voted[i]` is 0 and exactly one of yes-edge[i] / no-edge[i] is present: set `voted[i]` to 1 and set `ballot[i]` to the yes-edge value.
  - If both edges occur in the same cycle, the input is ignored and the voter may vote later.
  - Edges from an already-voted voter are ignored; votes cannot be changed.
- **OPEN** — close when any of these holds on a cycle:
  - `close` is 1,
  - `voted` OR'd with this cycle's new votes equals 4'b1111,
  - the timer equals TIMEOUT_CYCLES-1.
- On closing: votes accepted in that same cycle are recorded, and the state goes to DONE.
- `timed_out` is set only when the timer condition holds and neither other condition does.
- **OPEN** — otherwise the timer increments by 1 (wrap is impossible by construction). `start` is ignored.
- **DONE**
  - `ballot` and `voted` are frozen.
  - `ack`: go to IDLE.
  - `start` and buttons are ignored.
- `rst` in any state, including mid-session, forces the reset values on the next edge. Partial votes are discarded.

## Timing
- All outputs are registered.
- `start` sampled at edge k: `voting_open` is 1 from after edge k. The first vote edge is accepted from cycle k+1.
- Vote press visible at edge m: `voted`/`ballot` update after edge m.
- Closing condition at edge m: `voting_open` is 0 and `ballot_valid` is 1 after edge m.
- Timeout: the window lasts exactly TIMEOUT_CYCLES cycles in OPEN.
- `ack` at edge n: `ballot_valid` is 0 after edge n. A new `start` is accepted from edge n+1.

## Configuration
- `VOTE_TIMEOUT_EN` defined: the timer, the timeout close condition and `timed_out` exist as described.
- `VOTE_TIMEOUT_EN` undefined:
  - No timer is built.
  - OPEN exits only on `close` or all four votes.
  - `timed_out` is tied to 0.
  - `TIMEOUT_CYCLES` and `TMR_W` are unused.

## Structure
- Shared package `vote_pkg` holds:
  - `NUM_VOTERS` = 4,
  - the state enum `vote_state_t` {IDLE, OPEN, DONE},
  - the ballot typedef `ballot_t` (4-bit).
- One sub-module, `btn_edge_detect`, parameterised by width. It is instantiated once each for `yes_btn` and `no_btn` and outputs one-cycle rise pulses.

## Test plan
- Basic session: `start`, then yes on voters 0, 1 and 3 and no on voter 2.
  - `ballot`=4'b1011 and `voted`=4'b1111.
  - `ballot_valid` rises the cycle after the last vote; `ack` returns to IDLE.
- Early close: `start`, yes on voter 2 only, then `close`.
  - `ballot`=4'b0100, `voted`=4'b0100, `timed_out`=0.
- Timeout with TIMEOUT_CYCLES=8: `start` with no votes.
  - `ballot_valid` rises exactly 8 cycles after `voting_open` rises.
  - `ballot`=4'b0000, `timed_out`=1.
  - With the macro undefined, the block stays in OPEN indefinitely.
- Illegal and boundary inputs:
  - Voter 1 presses yes, then no: `ballot[1]` stays 1.
  - Simultaneous yes+no on voter 0 is ignored, and a later no is accepted.
  - A `yes_btn[3]` held high before `start` is not counted until re-pressed.
  - A vote in the same cycle as `close` is counted.
- Reset mid-session: after two votes, pulse `rst`. All outputs are 0 and the state is IDLE. `ack` and `start` are ignored during the reset cycle.
